// File: rtl/rx_frame_sequencer.sv
// Frame-level receive controller: sync acquisition, symbol/frame indexing,
// frame-aligned modulation/spreading config and datapath flush control.
module rx_frame_sequencer #(
    parameter int unsigned SYMB_PER_FRAME = 64,
    parameter int unsigned PREAMB_SYMB    = 2,
    parameter int unsigned FFT_LEN        = 1024,
    parameter int unsigned CP_LEN         = 32,
    parameter int unsigned TIMEOUT_SYM    = 4,
    parameter int unsigned RST_HOLD       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ifound_sync,
    input  logic       isop,
    input  logic [2:0] index_M_in,
    input  logic [3:0] index_SS_in,
    input  logic       icfg_upd,
    output logic       odel_rst,
    output logic [2:0] oindex_M,
    output logic [3:0] oindex_SS,
    output logic [6:0] osymb_idx,
    output logic       osof,
    output logic       oeof,
    output logic       opream,
    output logic       olost_sync,
    output logic [1:0] ostate
);

    localparam int unsigned TS       = FFT_LEN + CP_LEN;
    localparam int unsigned WD_LIMIT = TIMEOUT_SYM * TS;
    localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
    localparam int unsigned HOLD_W   = $clog2(RST_HOLD + 1);

    localparam logic [6:0]        LAST_IDX   = 7'(SYMB_PER_FRAME - 1);
    localparam logic [6:0]        PREAMB_IDX = 7'(PREAMB_SYMB);
    localparam logic [WD_W-1:0]   WD_HIT     = WD_W'(WD_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACQ   = 2'd2,
        ST_TRACK = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [WD_W-1:0]   wd_cnt, wd_n;
    logic [2:0]        pend_m, pend_m_n;
    logic [3:0]        pend_ss, pend_ss_n;
    logic              pend_flag, pend_flag_n;
    logic              del_n, sof_n, eof_n, pream_n, lost_n;
    logic [2:0]        m_n;
    logic [3:0]        ss_n;
    logic [6:0]        idx_n;
    logic              frame_start;

    assign ostate = state;

    // Next-state, counters, config hand-over and output values.
    always_comb begin
        state_n     = state;
        hold_n      = hold_cnt;
        wd_n        = wd_cnt;
        pend_m_n    = pend_m;
        pend_ss_n   = pend_ss;
        pend_flag_n = pend_flag;
        m_n         = oindex_M;
        ss_n        = oindex_SS;
        idx_n       = osymb_idx;
        del_n       = odel_rst;
        sof_n       = 1'b0;
        eof_n       = 1'b0;
        lost_n      = 1'b0;
        frame_start = 1'b0;

        case (state)
            ST_FLUSH: begin
                del_n = 1'b0;
                wd_n  = '0;
                if (hold_cnt == HOLD_LAST) begin
                    state_n = ST_IDLE;
                    del_n   = 1'b1;
                    hold_n  = '0;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                del_n = 1'b1;
                wd_n  = '0;
                if (ifound_sync) state_n = ST_ACQ;
            end
            default: begin
                // sync loss wins over a same-cycle strobe and the watchdog
                if (!ifound_sync) begin
                    lost_n  = 1'b1;
                    state_n = ST_FLUSH;
                    del_n   = 1'b0;
                    hold_n  = '0;
                end else if (isop) begin
                    wd_n    = '0;
                    state_n = ST_TRACK;
                    if (state == ST_ACQ || osymb_idx == LAST_IDX) begin
                        idx_n       = '0;
                        sof_n       = 1'b1;
                        frame_start = 1'b1;
                    end else begin
                        idx_n = osymb_idx + 7'd1;
                        eof_n = ((osymb_idx + 7'd1) == LAST_IDX);
                    end
                end else if (wd_cnt >= WD_HIT) begin
                    // the count reaches the limit on this edge
                    lost_n  = 1'b1;
                    state_n = ST_FLUSH;
                    del_n   = 1'b0;
                    hold_n  = '0;
                end else begin
                    wd_n = wd_cnt + 1'b1;
                end
            end
        endcase

        // pending config set in an earlier cycle is applied at frame start
        if (frame_start && pend_flag) begin
            m_n         = pend_m;
            ss_n        = pend_ss;
            pend_flag_n = 1'b0;
        end
        if (icfg_upd) begin
            pend_m_n    = index_M_in;
            pend_ss_n   = index_SS_in;
            pend_flag_n = 1'b1;
        end

        pream_n = (state_n == ST_TRACK) && (idx_n < PREAMB_IDX);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FLUSH;
            hold_cnt   <= '0;
            wd_cnt     <= '0;
            pend_m     <= '0;
            pend_ss    <= '0;
            pend_flag  <= 1'b0;
            odel_rst   <= 1'b0;
            oindex_M   <= '0;
            oindex_SS  <= '0;
            osymb_idx  <= '0;
            osof       <= 1'b0;
            oeof       <= 1'b0;
            opream     <= 1'b0;
            olost_sync <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            wd_cnt     <= wd_n;
            pend_m     <= pend_m_n;
            pend_ss    <= pend_ss_n;
            pend_flag  <= pend_flag_n;
            odel_rst   <= del_n;
            oindex_M   <= m_n;
            oindex_SS  <= ss_n;
            osymb_idx  <= idx_n;
            osof       <= sof_n;
            oeof       <= eof_n;
            opream     <= pream_n;
            olost_sync <= lost_n;
        end
    end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: directed scenarios plus random traffic,
// checked every cycle against a frame-counting behavioural model.
module tb_rx_frame_sequencer;

    localparam int SYMB = 64;
    localparam int PRE  = 2;
    localparam int TSYM = 1056;
    localparam int TO   = 4 * TSYM;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst, ifound_sync, isop, icfg_upd;
    logic [2:0] index_M_in;
    logic [3:0] index_SS_in;
    logic       odel_rst, osof, oeof, opream, olost_sync;
    logic [2:0] oindex_M;
    logic [3:0] oindex_SS;
    logic [6:0] osymb_idx;
    logic [1:0] ostate;

    always #5 clk = ~clk;

    rx_frame_sequencer dut (
        .clk(clk), .rst(rst), .ifound_sync(ifound_sync), .isop(isop),
        .index_M_in(index_M_in), .index_SS_in(index_SS_in), .icfg_upd(icfg_upd),
        .odel_rst(odel_rst), .oindex_M(oindex_M), .oindex_SS(oindex_SS),
        .osymb_idx(osymb_idx), .osof(osof), .oeof(oeof), .opream(opream),
        .olost_sync(olost_sync), .ostate(ostate)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 flush, 1 idle, 2 acquiring, 3 tracking
    int         mode, flush_age, since_sop, nsop;
    bit         pflag;
    logic [2:0] pm, e_m;
    logic [3:0] ps, e_ss;
    logic [6:0] e_idx;
    logic       e_del, e_sof, e_eof, e_pream, e_lost;
    bit         model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // outcome of the coming clock edge given the inputs now applied
    task automatic model_step();
        bit fs;
        int k;
        fs     = 1'b0;
        e_sof  = 1'b0;
        e_eof  = 1'b0;
        e_lost = 1'b0;
        if (!rst) begin
            mode = 0; flush_age = 0; since_sop = 0; nsop = 0;
            pflag = 1'b0; pm = '0; ps = '0; e_m = '0; e_ss = '0; e_idx = '0;
            e_pream = 1'b0; e_del = 1'b0; model_valid = 1'b1;
            return;
        end
        case (mode)
            0: begin
                flush_age++;
                if (flush_age == HOLD) mode = 1;
            end
            1: if (ifound_sync) begin
                mode = 2; since_sop = 0; nsop = 0;
            end
            default: begin
                if (!ifound_sync) begin
                    e_lost = 1'b1; mode = 0; flush_age = 0;
                end else if (isop) begin
                    nsop++;
                    mode = 3;
                    since_sop = 0;
                    k = (nsop - 1) % SYMB;
                    e_idx = 7'(k);
                    e_sof = (k == 0);
                    e_eof = (k == SYMB - 1);
                    fs = e_sof;
                end else begin
                    since_sop++;
                    if (since_sop >= TO) begin
                        e_lost = 1'b1; mode = 0; flush_age = 0;
                    end
                end
            end
        endcase
        if (fs && pflag) begin
            e_m = pm; e_ss = ps; pflag = 1'b0;
        end
        if (icfg_upd) begin
            pm = index_M_in; ps = index_SS_in; pflag = 1'b1;
        end
        e_del   = (mode != 0);
        e_pream = (mode == 3) && (int'(e_idx) < PRE);
    endtask

    // every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            n_tests++;
            if ({odel_rst, oindex_M, oindex_SS, osymb_idx, osof, oeof, opream, olost_sync, ostate} !==
                {e_del, e_m, e_ss, e_idx, e_sof, e_eof, e_pream, e_lost, 2'(mode)}) begin
                n_fail++;
                $display("FAIL cycle_cmp at %0t: got del=%b M=%0d SS=%0d idx=%0d sof=%b eof=%b pream=%b lost=%b st=%0d, expected del=%b M=%0d SS=%0d idx=%0d sof=%b eof=%b pream=%b lost=%b st=%0d",
                         $time, odel_rst, oindex_M, oindex_SS, osymb_idx, osof, oeof, opream, olost_sync, ostate,
                         e_del, e_m, e_ss, e_idx, e_sof, e_eof, e_pream, e_lost, mode);
            end
        end
    end

    task automatic cyc(input bit s, input bit p, input bit c, input logic [2:0] m,
                       input logic [3:0] ss, input bit r);
        rst = r; ifound_sync = s; isop = p; icfg_upd = c;
        index_M_in = m; index_SS_in = ss;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle1(input bit s);
        cyc(s, 1'b0, 1'b0, 3'($urandom), 4'($urandom), 1'b1);
    endtask

    task automatic gap_sop(input int gap);
        repeat (gap - 1) idle1(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 3'($urandom), 4'($urandom), 1'b1);
    endtask

    initial begin
        int  n;
        bit  s, p, c, r, prev_p, sync_lvl;
        rst = 1'b0; ifound_sync = 1'b0; isop = 1'b0; icfg_upd = 1'b0;
        index_M_in = '0; index_SS_in = '0;
        @(negedge clk);

        // reset and flush hold after release
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("rst_del", odel_rst, 0);
        check("rst_state", ostate, 0);
        check("rst_idx", osymb_idx, 0);
        repeat (15) idle1(1'b0);
        check("hold_low_15", odel_rst, 0);
        idle1(1'b0);
        check("hold_release", odel_rst, 1);
        check("idle_state", ostate, 1);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        check("idle_ignores_sop", osof, 0);
        check("idle_stays", ostate, 1);
        idle1(1'b1);
        check("acq_state", ostate, 2);

        // symbols at the nominal period
        gap_sop(TSYM);
        check("first_sof", osof, 1);
        check("first_idx", osymb_idx, 0);
        check("first_pream", opream, 1);
        check("track_state", ostate, 3);
        gap_sop(TSYM);
        check("idx1", osymb_idx, 1);
        check("pream1", opream, 1);
        gap_sop(TSYM);
        check("idx2", osymb_idx, 2);
        check("pream2", opream, 0);

        // mid-frame config waits for the next frame start
        cyc(1'b1, 1'b0, 1'b1, 3'd4, 4'd3, 1'b1);
        repeat (60) gap_sop(3);
        check("idx62", osymb_idx, 62);
        check("m_held", oindex_M, 0);
        gap_sop(3);
        check("eof63", oeof, 1);
        check("idx63", osymb_idx, 63);
        idle1(1'b1);
        idle1(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 3'd2, 4'd5, 1'b1);
        check("wrap_sof", osof, 1);
        check("wrap_idx", osymb_idx, 0);
        check("cfg_m_applied", oindex_M, 4);
        check("cfg_ss_applied", oindex_SS, 3);
        repeat (63) gap_sop(3);
        check("eof_f2", oeof, 1);
        gap_sop(3);
        check("sof_f3", osof, 1);
        check("cfg2_m", oindex_M, 2);
        check("cfg2_ss", oindex_SS, 5);

        // watchdog after withheld symbols
        gap_sop(3);
        n = 0;
        while (olost_sync !== 1'b1 && n < 5000) begin
            idle1(1'b1);
            n++;
        end
        check("wd_cycles", n, TO);
        check("wd_del_low", odel_rst, 0);
        check("wd_flush", ostate, 0);
        repeat (15) idle1(1'b1);
        check("wd_hold_low", odel_rst, 0);
        idle1(1'b1);
        check("wd_hold_release", odel_rst, 1);
        check("wd_idle", ostate, 1);
        idle1(1'b1);
        check("wd_reacq", ostate, 2);

        // sync drop coinciding with a symbol strobe
        repeat (5) gap_sop(3);
        check("pre_drop_idx", osymb_idx, 4);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        check("drop_lost", olost_sync, 1);
        check("drop_idx", osymb_idx, 4);
        check("drop_nosof", osof, 0);
        check("drop_flush", ostate, 0);
        idle1(1'b0);
        check("drop_single_pulse", olost_sync, 0);
        repeat (15) idle1(1'b0);
        idle1(1'b1);
        check("drop_reacq", ostate, 2);

        // reset pulse mid-frame
        repeat (31) gap_sop(3);
        check("idx30", osymb_idx, 30);
        idle1(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("mid_rst_del", odel_rst, 0);
        check("mid_rst_m", oindex_M, 0);
        check("mid_rst_ss", oindex_SS, 0);
        check("mid_rst_idx", osymb_idx, 0);
        check("mid_rst_state", ostate, 0);
        check("mid_rst_pream", opream, 0);
        repeat (16) idle1(1'b1);
        check("mid_rst_idle", ostate, 1);

        // random traffic against the model
        prev_p = 1'b0;
        sync_lvl = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (sync_lvl) sync_lvl = ($urandom_range(0, 299) != 0);
            else          sync_lvl = ($urandom_range(0, 19) == 0);
            s = sync_lvl;
            r = ($urandom_range(0, 1999) != 0);
            p = !prev_p && ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 29) == 0);
            cyc(s, p, c, 3'($urandom), 4'($urandom), r);
            prev_p = p;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_frame_sequencer.md
# rx_frame_sequencer

Frame-level controller for the OFDM receive chain. It takes correlator sync status and the symbol-start strobe from CP removal, and drives the datapath soft reset. It tracks the symbol index within a frame and marks preamble symbols. Modulation (M) and spreading (SS) indices are applied only on frame boundaries. It sits between the sync filter / CP-removal stage and the demapper / equalizer configuration inputs, and its outputs drive everything downstream of CP removal.

## Interface
Parameters:
- SYMB_PER_FRAME, 64: OFDM symbols per frame (2..127).
- PREAMB_SYMB, 2: leading symbols per frame that are preamble (< SYMB_PER_FRAME).
- FFT_LEN, 1024: FFT size in samples.
- CP_LEN, 32: cyclic prefix length in samples; symbol period Ts = FFT_LEN+CP_LEN.
- TIMEOUT_SYM, 4: missing-symbol tolerance, in Ts units.
- RST_HOLD, 16: cycles odel_rst is held low per flush.

Ports:
- clk  in  1  sample clock (clk_low_data domain).
- rst  in  1  synchronous, active-low reset.
- ifound_sync  in  1  level, sync filter locked.
- isop  in  1  one-cycle strobe, first sample of a CP-stripped symbol.
- index_M_in  in  3  requested modulation index.
- index_SS_in  in  4  requested spreading index.
- icfg_upd  in  1  strobe, latch index_M_in/index_SS_in as pending.
- odel_rst  out  1  datapath soft reset, active-low.
- oindex_M  out  3  active modulation index.
- oindex_SS  out  4  active spreading index.
- osymb_idx  out  7  symbol index within frame.
- osof  out  1  strobe, first symbol of frame.
- oeof  out  1  strobe, last symbol of frame.
- opream  out  1  level, current symbol is preamble.
- olost_sync  out  1  strobe, watchdog or sync-loss flush.
- ostate  out  2  FLUSH=0, IDLE=1, ACQ=2, TRACK=3.

## Operation
- FLUSH: odel_rst=0. The hold counter counts RST_HOLD cycles, then the block goes to IDLE with odel_rst=1. isop is ignored.
- IDLE: isop is ignored. When ifound_sync=1, go to ACQ.
- ACQ: the watchdog runs. On the first isop: osymb_idx=0, pulse osof, apply pending config if flagged, go to TRACK.
- TRACK: each isop increments osymb_idx.
  - At SYMB_PER_FRAME-1, the index wraps to 0 with osof and applies pending config.
  - oeof pulses on the isop that sets osymb_idx=SYMB_PER_FRAME-1.
  - opream=1 while osymb_idx<PREAMB_SYMB; it is 0 outside TRACK.
- Watchdog (ACQ, TRACK): the cycle counter clears on isop and saturates. Width is ceil(log2(TIMEOUT_SYM*Ts+1)), which is 13 bits at defaults. When the count reaches TIMEOUT_SYM*Ts (4224), pulse olost_sync and go to FLUSH.
- Sync loss: ifound_sync=0 in ACQ or TRACK pulses olost_sync and goes to FLUSH. This has priority over a same-cycle isop and over the watchdog (one pulse only).
- Config:
  - icfg_upd writes the pending registers and sets the pending flag. A later icfg_upd overwrites them (last wins).
  - At an osof cycle, a flag set in an earlier cycle copies pending to oindex_M/oindex_SS and clears the flag.
  - An icfg_upd in that same osof cycle is stored as the new pending value and leaves the flag set for the next frame.
- A flush does not change oindex_M/oindex_SS or the pending registers.

## Timing
- All outputs are registered.
- Latency from input strobe to output is 1 cycle:
  - osof, oeof and osymb_idx follow the sampled isop by 1 cycle.
  - olost_sync follows the sampled ifound_sync fall or the watchdog hit by 1 cycle.
  - oindex_M/oindex_SS change in the same cycle osof asserts.
- odel_rst falls in the cycle after the FLUSH entry decision and stays low exactly RST_HOLD cycles. IDLE is entered on the edge odel_rst rises.
- rst=0 at any clock edge forces these values on the next edge, including mid-frame:
  - state FLUSH, hold counter 0, odel_rst 0;
  - oindex_M 0, oindex_SS 0, osymb_idx 0;
  - osof, oeof, opream, olost_sync 0;
  - pending flag and watchdog 0.
- isop on consecutive cycles (illegal upstream) still increments once per strobe. This behaviour is not checked.

## Test plan
- Reset release with ifound_sync=0 → odel_rst=0 for 16 cycles, then 1; ostate=1; no osof.
- ifound_sync=1, isop every 1056 cycles → first isop gives osof, osymb_idx=0, opream=1. Symbol 2 gives opream=0. Symbol 63 gives oeof. Symbol 64 gives osymb_idx=0 and osof.
- icfg_upd with M=4, SS=3 mid-frame → oindex_M/SS unchanged until the next osof cycle, then 4/3. icfg_upd coinciding with that osof carrying M=2 → applied at the following frame's osof.
- In TRACK, withhold isop → olost_sync pulses 4224 cycles after the last isop, odel_rst goes low 16 cycles, ostate goes to IDLE, then back to ACQ while ifound_sync=1.
- ifound_sync drop coinciding with isop in TRACK → a single olost_sync, no osymb_idx increment, FLUSH entered.
- rst=0 pulse during symbol 30 → all outputs at reset values next cycle, followed by a full flush sequence.
